// File: rtl/sram_mem_ctrl.sv
// Single-port SRAM controller: byte/half/word access with credit-limited,
// in-order responses through a fixed-latency pipeline and response FIFO.
package memory_types_pkg;
    typedef enum logic {
        MEM_READ  = 1'b0,
        MEM_WRITE = 1'b1
    } mem_type_t;

    typedef struct packed {
        mem_type_t   mtype;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_pkt_t;
endpackage

module sram_mem_ctrl
    import memory_types_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS     = 1024,
    parameter int unsigned LATENCY         = 2,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     req_vld,
    output logic     req_rdy,
    input  mem_pkt_t req,
    output logic     rsp_vld,
    input  logic     rsp_rdy,
    output mem_pkt_t rsp,
    output logic     misalign
);
    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]   r_mem [DEPTH_WORDS];
    logic [OW-1:0] r_outstanding;
    mem_pkt_t      r_fifo [MAX_OUTSTANDING];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [OW-1:0] r_count;

    logic          w_acc;
    logic          w_pop;
    logic          w_is_byte;
    logic          w_is_half;
    logic          w_misal;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_rword;
    logic [31:0]   w_rdata;
    logic [31:0]   w_wdata;
    logic [3:0]    w_be;
    mem_pkt_t      w_new_pkt;
    logic          w_push_vld;
    mem_pkt_t      w_push_pkt;

    assign req_rdy  = (r_outstanding < OW'(MAX_OUTSTANDING)) && !rst;
    assign w_acc    = req_vld && req_rdy;
    assign rsp_vld  = (r_count != '0) && !rst;
    assign w_pop    = rsp_vld && rsp_rdy;
    assign rsp      = rsp_vld ? r_fifo[r_rptr] : '0;
    assign misalign = w_acc && w_misal;

    // Decode size, form byte enables and the right-justified read data.
    always_comb begin
        w_is_byte = (req.len == 2'b01);
        w_is_half = (req.len == 2'b10);
        w_idx     = req.addr[AW+1:2];
        w_misal   = (w_is_half && req.addr[0]) ||
                    (!w_is_byte && !w_is_half && (req.addr[1:0] != 2'b00));
        w_rword   = r_mem[w_idx];
        w_rdata   = w_rword;
        w_wdata   = req.data;
        w_be      = 4'b1111;
        if (w_is_byte) begin
            w_rdata = {24'b0, w_rword[{req.addr[1:0], 3'b000} +: 8]};
            w_wdata = {4{req.data[7:0]}};
            w_be    = 4'b0001 << req.addr[1:0];
        end else if (w_is_half) begin
            w_rdata = {16'b0, w_rword[{req.addr[1], 4'b0000} +: 16]};
            w_wdata = {2{req.data[15:0]}};
            w_be    = req.addr[1] ? 4'b1100 : 4'b0011;
        end
        if (w_misal || (req.mtype == MEM_WRITE)) begin
            w_rdata = '0;
        end
        w_new_pkt      = req;
        w_new_pkt.data = w_rdata;
    end

    // Array is intentionally never reset.
    always_ff @(posedge clk) begin
        if (w_acc && (req.mtype == MEM_WRITE) && !w_misal) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_outstanding <= '0;
        end else begin
            case ({w_acc, w_pop})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // The FIFO write is the last latency stage, so only LATENCY-1 registers precede it.
    generate
        if (LATENCY == 1) begin : g_nopipe
            assign w_push_vld = w_acc;
            assign w_push_pkt = w_new_pkt;
        end else begin : g_pipe
            logic [LATENCY-2:0] r_vld;
            mem_pkt_t           r_pkt [LATENCY-1];

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_vld <= '0;
                end else begin
                    r_vld <= {r_vld, w_acc};
                end
            end

            always_ff @(posedge clk) begin
                r_pkt[0] <= w_new_pkt;
                for (int unsigned i = 1; i < LATENCY - 1; i++) begin
                    r_pkt[i] <= r_pkt[i-1];
                end
            end

            assign w_push_vld = r_vld[LATENCY-2];
            assign w_push_pkt = r_pkt[LATENCY-2];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_vld) begin
                r_wptr <= (r_wptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : r_rptr + 1'b1;
            end
            case ({w_push_vld, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_vld) begin
            r_fifo[r_wptr] <= w_push_pkt;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_push_vld && !w_pop && (r_count == OW'(MAX_OUTSTANDING))));

endmodule
